// File: rtl/dbg_stream_bridge.sv
// dbg_stream_bridge
// Avalon-MM debug-console slave that moves bytes between a processor data
// master and a generic valid/ready byte transport (UART, USB or SPI bridge).
// Avalon writes to DATA go into a TX FIFO that streams out on tx_*.
// Beats arriving on rx_* fill an RX FIFO that is drained by Avalon DATA reads.
//
// Ports:
//   clk, rst_n        system clock, asynchronous active-low reset
//   av_address        word address: 0 DATA, 1 CONTROL, 2 THRESH, 3 STATUS
//   av_chipselect     slave select
//   av_read_n         read strobe, active low
//   av_write_n        write strobe, active low
//   av_writedata      write data
//   av_readdata       registered read data, valid while av_waitrequest is low
//   av_waitrequest    Avalon wait; every access completes on its second cycle
//   av_irq            registered interrupt request
//   tx_data/tx_valid  TX FIFO head (first-word-fall-through) and not-empty flag
//   tx_ready          sink accepts the TX head
//   rx_data/rx_valid  incoming beat and its valid flag
//   rx_ready          block accepts an incoming beat
module dbg_stream_bridge #(
   parameter int DW         = 8,
   parameter int TX_DEPTH   = 64,
   parameter int RX_DEPTH   = 64,
   parameter int TX_THR_RST = 8,
   parameter int RX_THR_RST = 1,
   parameter int RX_DROP    = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    av_address,
   input  logic          av_chipselect,
   input  logic          av_read_n,
   input  logic          av_write_n,
   input  logic [31:0]   av_writedata,
   output logic [31:0]   av_readdata,
   output logic          av_waitrequest,
   output logic          av_irq,
   output logic [DW-1:0] tx_data,
   output logic          tx_valid,
   input  logic          tx_ready,
   input  logic [DW-1:0] rx_data,
   input  logic          rx_valid,
   output logic          rx_ready
);

   localparam int TX_AW = $clog2(TX_DEPTH);
   localparam int RX_AW = $clog2(RX_DEPTH);
   localparam logic [TX_AW:0] TX_FULL_CNT = TX_DEPTH[TX_AW:0];
   localparam logic [RX_AW:0] RX_FULL_CNT = RX_DEPTH[RX_AW:0];

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_CONTROL = 2'd1;
   localparam logic [1:0] ADDR_THRESH  = 2'd2;
   localparam logic [1:0] ADDR_STATUS  = 2'd3;

   // Avalon handshake and register state
   logic          r_waitrequest;
   logic [31:0]   r_readdata;
   logic          r_irq;
   logic [2:0]    r_ien;
   logic [15:0]   r_txThr;
   logic [15:0]   r_rxThr;
   logic          r_wovf;
   logic          r_rovf;

   // FIFO storage and pointers
   logic [DW-1:0] r_txMem [TX_DEPTH];
   logic [TX_AW-1:0] r_txWrPtr;
   logic [TX_AW-1:0] r_txRdPtr;
   logic [TX_AW:0]   r_txUsed;
   logic [DW-1:0] r_rxMem [RX_DEPTH];
   logic [RX_AW-1:0] r_rxWrPtr;
   logic [RX_AW-1:0] r_rxRdPtr;
   logic [RX_AW:0]   r_rxUsed;

   logic          w_rdAcc;
   logic          w_wrAcc;
   logic          w_txEmpty;
   logic          w_txFull;
   logic          w_txPush;
   logic          w_txPop;
   logic          w_rxEmpty;
   logic          w_rxFull;
   logic          w_rxReady;
   logic          w_rxPush;
   logic          w_rxPop;
   logic          w_wovfSet;
   logic          w_rovfSet;
   logic          w_statusWr;
   logic [15:0]   w_txUsed16;
   logic [15:0]   w_rxUsed16;
   logic [15:0]   w_txFree;
   logic [15:0]   w_rxThrEff;
   logic          w_rxIp;
   logic          w_txIp;
   logic          w_ovfIp;
   logic [31:0]   w_readMux;

   // An access only takes effect on its first cycle (waitrequest still high),
   // so a read or write held for two cycles acts exactly once.
   assign w_rdAcc    = av_chipselect & r_waitrequest & ~av_read_n;
   assign w_wrAcc    = av_chipselect & r_waitrequest & ~av_write_n;
   assign w_statusWr = w_wrAcc & (av_address == ADDR_STATUS);

   // Full and empty come from the registered counts, so a push into a full
   // FIFO is refused even when the same cycle also pops it.
   assign w_txEmpty = (r_txUsed == '0);
   assign w_txFull  = (r_txUsed == TX_FULL_CNT);
   assign w_txPush  = w_wrAcc & (av_address == ADDR_DATA) & ~w_txFull;
   assign w_txPop   = ~w_txEmpty & tx_ready;
   assign w_wovfSet = w_wrAcc & (av_address == ADDR_DATA) & w_txFull;

   assign w_rxEmpty = (r_rxUsed == '0);
   assign w_rxFull  = (r_rxUsed == RX_FULL_CNT);
   assign w_rxReady = (RX_DROP != 0) ? 1'b1 : ~w_rxFull;
   assign w_rxPush  = rx_valid & w_rxReady & ~w_rxFull;
   assign w_rxPop   = w_rdAcc & (av_address == ADDR_DATA) & ~w_rxEmpty;
   assign w_rovfSet = (RX_DROP != 0) & rx_valid & w_rxFull;

   assign w_txUsed16 = 16'(r_txUsed);
   assign w_rxUsed16 = 16'(r_rxUsed);
   assign w_txFree   = 16'(TX_DEPTH) - w_txUsed16;
   assign w_rxThrEff = (r_rxThr == 16'd0) ? 16'd1 : r_rxThr;

   assign w_rxIp  = r_ien[0] & (w_rxUsed16 >= w_rxThrEff);
   assign w_txIp  = r_ien[1] & (w_txUsed16 <= r_txThr);
   assign w_ovfIp = r_ien[2] & (r_wovf | r_rovf);

   assign av_readdata    = r_readdata;
   assign av_waitrequest = r_waitrequest;
   assign av_irq         = r_irq;
   assign tx_data        = r_txMem[r_txRdPtr];
   assign tx_valid       = ~w_txEmpty;
   assign rx_ready       = w_rxReady;

   // FIFO storage has no reset; only the pointers and counts define contents.
   always_ff @(posedge clk) begin
      if (w_txPush) begin
         r_txMem[r_txWrPtr] <= av_writedata[DW-1:0];
      end
      if (w_rxPush) begin
         r_rxMem[r_rxWrPtr] <= rx_data;
      end
   end

   // TX pointers and count; pointers wrap naturally because depth is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_txWrPtr <= '0;
         r_txRdPtr <= '0;
         r_txUsed  <= '0;
      end else begin
         if (w_txPush) begin
            r_txWrPtr <= r_txWrPtr + 1'b1;
         end
         if (w_txPop) begin
            r_txRdPtr <= r_txRdPtr + 1'b1;
         end
         if (w_txPush && !w_txPop) begin
            r_txUsed <= r_txUsed + 1'b1;
         end else if (!w_txPush && w_txPop) begin
            r_txUsed <= r_txUsed - 1'b1;
         end
      end
   end

   // RX pointers and count, mirroring the TX side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rxWrPtr <= '0;
         r_rxRdPtr <= '0;
         r_rxUsed  <= '0;
      end else begin
         if (w_rxPush) begin
            r_rxWrPtr <= r_rxWrPtr + 1'b1;
         end
         if (w_rxPop) begin
            r_rxRdPtr <= r_rxRdPtr + 1'b1;
         end
         if (w_rxPush && !w_rxPop) begin
            r_rxUsed <= r_rxUsed + 1'b1;
         end else if (!w_rxPush && w_rxPop) begin
            r_rxUsed <= r_rxUsed - 1'b1;
         end
      end
   end

   // Read data for the addressed register, as seen before this cycle's pop.
   always_comb begin
      w_readMux = '0;
      case (av_address)
         ADDR_DATA: begin
            w_readMux[31:16] = w_rxUsed16;
            w_readMux[15]    = ~w_rxEmpty;
            if (!w_rxEmpty) begin
               w_readMux[DW-1:0] = r_rxMem[r_rxRdPtr];
            end
         end
         ADDR_CONTROL: begin
            w_readMux[31:16] = w_txFree;
            w_readMux[10:8]  = {w_ovfIp, w_txIp, w_rxIp};
            w_readMux[2:0]   = r_ien;
         end
         ADDR_THRESH: begin
            w_readMux = {r_rxThr, r_txThr};
         end
         default: begin
            w_readMux[31:16] = w_rxUsed16;
            w_readMux[3:0]   = {w_rxFull, w_txEmpty, r_rovf, r_wovf};
         end
      endcase
   end

   // Handshake, read capture and the registered interrupt. waitrequest drops
   // for exactly one cycle after the first cycle of an access.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_waitrequest <= 1'b1;
         r_readdata    <= '0;
         r_irq         <= 1'b0;
      end else begin
         r_waitrequest <= ~(av_chipselect & (~av_read_n | ~av_write_n) & r_waitrequest);
         if (w_rdAcc) begin
            r_readdata <= w_readMux;
         end
         r_irq <= w_rxIp | w_txIp | w_ovfIp;
      end
   end

   // Control, threshold and sticky overflow flags. A set event in the same
   // cycle as a write-1-to-clear keeps the flag set.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ien   <= '0;
         r_txThr <= 16'(TX_THR_RST);
         r_rxThr <= 16'(RX_THR_RST);
         r_wovf  <= 1'b0;
         r_rovf  <= 1'b0;
      end else begin
         if (w_wrAcc && (av_address == ADDR_CONTROL)) begin
            r_ien <= av_writedata[2:0];
         end
         if (w_wrAcc && (av_address == ADDR_THRESH)) begin
            r_txThr <= av_writedata[15:0];
            r_rxThr <= av_writedata[31:16];
         end
         if (w_wovfSet) begin
            r_wovf <= 1'b1;
         end else if (w_statusWr && av_writedata[0]) begin
            r_wovf <= 1'b0;
         end
         if (w_rovfSet) begin
            r_rovf <= 1'b1;
         end else if (w_statusWr && av_writedata[1]) begin
            r_rovf <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_dbg_stream_bridge.sv
// Testbench for dbg_stream_bridge. Two instances share the Avalon bus
// signals: dutMain uses default parameters, dutDrop uses RX_DROP=1 with a
// 4-deep RX FIFO. 'sel' picks which instance the Avalon tasks address.
// Expected Avalon read data and expected TX bytes are queued as stimulus is
// issued; a monitor pops and compares whenever the DUT presents them.
module tb_dbg_stream_bridge;

   typedef struct {
      string       name;
      logic [31:0] val;
   } expItem_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  av_address;
   logic        av_chipselect;
   logic        av_read_n;
   logic        av_write_n;
   logic [31:0] av_writedata;
   logic        sel;
   logic        txReady;
   logic        rxValidMain;
   logic        rxValidDrop;
   logic [7:0]  rxData;

   logic [31:0] rdMain, rdDrop, curRead;
   logic        waitMain, waitDrop, curWait;
   logic        irqMain, irqDrop;
   logic [7:0]  txDataMain, txDataDrop;
   logic        txValidMain, txValidDrop;
   logic        rxReadyMain, rxReadyDrop;
   logic        csMain, csDrop;

   expItem_t    expRead[$];
   logic [7:0]  expTx[$];
   int          checks = 0;
   int          errors = 0;

   assign csMain  = av_chipselect & ~sel;
   assign csDrop  = av_chipselect & sel;
   assign curRead = sel ? rdDrop : rdMain;
   assign curWait = sel ? waitDrop : waitMain;

   always #5 clk = ~clk;

   dbg_stream_bridge dutMain (
      .clk(clk), .rst_n(rst_n),
      .av_address(av_address), .av_chipselect(csMain),
      .av_read_n(av_read_n), .av_write_n(av_write_n),
      .av_writedata(av_writedata), .av_readdata(rdMain),
      .av_waitrequest(waitMain), .av_irq(irqMain),
      .tx_data(txDataMain), .tx_valid(txValidMain), .tx_ready(txReady),
      .rx_data(rxData), .rx_valid(rxValidMain), .rx_ready(rxReadyMain)
   );

   dbg_stream_bridge #(.RX_DEPTH(4), .RX_DROP(1)) dutDrop (
      .clk(clk), .rst_n(rst_n),
      .av_address(av_address), .av_chipselect(csDrop),
      .av_read_n(av_read_n), .av_write_n(av_write_n),
      .av_writedata(av_writedata), .av_readdata(rdDrop),
      .av_waitrequest(waitDrop), .av_irq(irqDrop),
      .tx_data(txDataDrop), .tx_valid(txValidDrop), .tx_ready(1'b0),
      .rx_data(rxData), .rx_valid(rxValidDrop), .rx_ready(rxReadyDrop)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // One Avalon access; returns the number of cycles until completion.
   task automatic applyStimulus(input logic [1:0] a, input logic isRead,
                                input logic [31:0] d, output int cycles);
      av_address    = a;
      av_writedata  = d;
      av_chipselect = 1'b1;
      av_read_n     = ~isRead;
      av_write_n    = isRead;
      cycles = 0;
      do begin
         @(posedge clk); #1;
         cycles++;
      end while (curWait && cycles < 20);
      if (curWait) begin
         checks++;
         errors++;
         $display("[TB] FAIL waitTimeout: got waitrequest=1 after %0d cycles expected 0", cycles);
      end
      @(posedge clk); #1;
      cycles++;
      av_chipselect = 1'b0;
      av_read_n     = 1'b1;
      av_write_n    = 1'b1;
   endtask

   task automatic avWrite(input logic [1:0] a, input logic [31:0] d);
      int c;
      applyStimulus(a, 1'b0, d, c);
   endtask

   task automatic avRead(input logic [1:0] a, input logic [31:0] exp, input string name);
      expItem_t item;
      int c;
      item.name = name;
      item.val  = exp;
      expRead.push_back(item);
      applyStimulus(a, 1'b1, 32'h0, c);
   endtask

   task automatic drainTx();
      txReady = 1'b1;
      repeat (70) @(posedge clk);
      #1;
      txReady = 1'b0;
      checkOutput("txDrainedValid", {31'b0, txValidMain}, 32'h0);
      checkOutput("txQueueEmpty", expTx.size(), 32'h0);
   endtask

   // Scoreboard monitor: compares Avalon read data and accepted TX beats.
   always @(negedge clk) begin
      expItem_t item;
      if (rst_n && av_chipselect && !av_read_n && !curWait) begin
         if (expRead.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedRead: got 0x%08h expected no read", curRead);
         end else begin
            item = expRead.pop_front();
            checkOutput(item.name, curRead, item.val);
         end
      end
      if (rst_n && txValidMain && txReady) begin
         if (expTx.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedTx: got 0x%02h expected no beat", txDataMain);
         end else begin
            checkOutput("txData", {24'h0, txDataMain}, {24'h0, expTx.pop_front()});
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int c;
      rst_n = 1'b1;
      sel = 1'b0;
      av_address = 2'd0;
      av_chipselect = 1'b0;
      av_read_n = 1'b1;
      av_write_n = 1'b1;
      av_writedata = 32'h0;
      txReady = 1'b0;
      rxValidMain = 1'b0;
      rxValidDrop = 1'b0;
      rxData = 8'h0;

      // Reset for three cycles
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      checkOutput("rstWait", {31'b0, waitMain}, 32'h1);
      checkOutput("rstTxValid", {31'b0, txValidMain}, 32'h0);
      checkOutput("rstRxReady", {31'b0, rxReadyMain}, 32'h1);
      checkOutput("rstIrq", {31'b0, irqMain}, 32'h0);
      checkOutput("rstReaddata", rdMain, 32'h0);
      checkOutput("rstDropRxReady", {31'b0, rxReadyDrop}, 32'h1);
      avRead(2'd1, 32'h0040_0000, "ctrlReset");
      avRead(2'd2, 32'h0001_0008, "threshReset");

      // Three bytes held in the TX FIFO, then streamed out back to back
      for (int i = 0; i < 3; i++) begin
         expTx.push_back(8'h41 + 8'(i));
         applyStimulus(2'd0, 1'b0, 32'h41 + 32'(i), c);
         checkOutput("writeCycles", c, 32'd2);
      end
      txReady = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("txEmptyAfter3", {31'b0, txValidMain}, 32'h0);
      txReady = 1'b0;

      // 65 writes into a 64-deep FIFO: the last is dropped
      for (int i = 0; i < 65; i++) begin
         if (i < 64) expTx.push_back(8'(i + 16));
         avWrite(2'd0, 32'(i + 16));
      end
      avRead(2'd3, 32'h0000_0001, "statusWovf");
      avRead(2'd1, 32'h0000_0000, "ctrlFull");
      avWrite(2'd3, 32'h1);
      avRead(2'd3, 32'h0000_0000, "statusWovfCleared");
      drainTx();

      // RX threshold interrupt
      avWrite(2'd1, 32'h1);
      avWrite(2'd2, 32'h0004_0008);
      for (int i = 0; i < 4; i++) begin
         rxData = 8'hA1 + 8'(i);
         rxValidMain = 1'b1;
         @(posedge clk); #1;
      end
      rxValidMain = 1'b0;
      checkOutput("irqAt4thPush", {31'b0, irqMain}, 32'h0);
      @(posedge clk); #1;
      checkOutput("irqAfter4thPush", {31'b0, irqMain}, 32'h1);
      avRead(2'd0, 32'h0004_80A1, "rxRead1");
      checkOutput("irqAfterPop", {31'b0, irqMain}, 32'h0);
      avRead(2'd0, 32'h0003_80A2, "rxRead2");
      avRead(2'd0, 32'h0002_80A3, "rxRead3");
      avRead(2'd0, 32'h0001_80A4, "rxRead4");
      avRead(2'd0, 32'h0000_0000, "rxReadEmpty");
      avWrite(2'd1, 32'h0);

      // Full TX FIFO: pop and dropped write in the same cycle
      for (int i = 0; i < 64; i++) begin
         expTx.push_back(8'(i + 100));
         avWrite(2'd0, 32'(i + 100));
      end
      av_address = 2'd0;
      av_writedata = 32'hEE;
      av_chipselect = 1'b1;
      av_write_n = 1'b0;
      txReady = 1'b1;
      @(posedge clk); #1;
      txReady = 1'b0;
      checkOutput("fullWriteWait", {31'b0, waitMain}, 32'h0);
      @(posedge clk); #1;
      av_chipselect = 1'b0;
      av_write_n = 1'b1;
      avRead(2'd1, 32'h0001_0000, "ctrlFree1");
      avRead(2'd3, 32'h0000_0001, "statusWovfPop");
      avWrite(2'd3, 32'h1);
      drainTx();

      // RX_DROP instance: 6 beats into a 4-deep FIFO
      sel = 1'b1;
      for (int i = 0; i < 6; i++) begin
         rxData = 8'hB1 + 8'(i);
         rxValidDrop = 1'b1;
         checkOutput("dropRxReady", {31'b0, rxReadyDrop}, 32'h1);
         @(posedge clk); #1;
      end
      rxValidDrop = 1'b0;
      checkOutput("dropRxReadyFull", {31'b0, rxReadyDrop}, 32'h1);
      avRead(2'd3, 32'h0004_000E, "dropStatus");
      avRead(2'd0, 32'h0004_80B1, "dropRead1");
      avRead(2'd0, 32'h0003_80B2, "dropRead2");
      avRead(2'd0, 32'h0002_80B3, "dropRead3");
      avRead(2'd0, 32'h0001_80B4, "dropRead4");
      avRead(2'd0, 32'h0000_0000, "dropReadEmpty");
      sel = 1'b0;

      // Reset in the middle of an access
      avWrite(2'd0, 32'h55);
      avWrite(2'd1, 32'h2);
      checkOutput("preRstIrq", {31'b0, irqMain}, 32'h1);
      checkOutput("preRstTxValid", {31'b0, txValidMain}, 32'h1);
      av_address = 2'd1;
      av_chipselect = 1'b1;
      av_read_n = 1'b0;
      @(posedge clk); #1;
      checkOutput("midWait", {31'b0, waitMain}, 32'h0);
      checkOutput("midReaddata", rdMain, 32'h003F_0202);
      rst_n = 1'b0;
      #1;
      checkOutput("asyncRstWait", {31'b0, waitMain}, 32'h1);
      checkOutput("asyncRstReaddata", rdMain, 32'h0);
      checkOutput("asyncRstIrq", {31'b0, irqMain}, 32'h0);
      checkOutput("asyncRstTxValid", {31'b0, txValidMain}, 32'h0);
      checkOutput("asyncRstRxReady", {31'b0, rxReadyMain}, 32'h1);
      av_chipselect = 1'b0;
      av_read_n = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      avRead(2'd2, 32'h0001_0008, "threshAfterRst");
      avRead(2'd1, 32'h0040_0000, "ctrlAfterRst");

      repeat (2) @(posedge clk);
      #1;
      checkOutput("readQueueEmpty", expRead.size(), 32'h0);
      checkOutput("dropIrq", {31'b0, irqDrop}, 32'h0);
      checkOutput("dropTxValid", {31'b0, txValidDrop}, 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dbg_stream_bridge.md
Name: dbg_stream_bridge

Overview:
- Parametrised successor to the team's Avalon-MM JTAG debug-console slave; the JTAG transport is replaced by generic valid/ready byte streams.
- Contains a TX FIFO (Avalon writes → stream out) and an RX FIFO (stream in → Avalon reads), both inferred register arrays.
- Depths, data width, IRQ thresholds and RX overflow mode are parameters.
- Sits between the Nios II data master and a debug transport (UART, USB, or SPI bridge).

Parameters:
- DW, 8, stream data width; legal range 1..15.
- TX_DEPTH, 64, TX FIFO depth; power of two, 2..32768.
- RX_DEPTH, 64, RX FIFO depth; power of two, 2..32768.
- TX_THR_RST, 8, reset value of the TX low-water threshold.
- RX_THR_RST, 1, reset value of the RX high-water threshold.
- RX_DROP, 0, RX mode. 0 = backpressure (rx_ready = ~rx_full). 1 = rx_ready is tied to 1; a beat arriving while full is dropped and sets ROVF.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- av_address  in  2  word address: 0 DATA, 1 CONTROL, 2 THRESH, 3 STATUS
- av_chipselect  in  1  slave select
- av_read_n  in  1  read strobe, active low
- av_write_n  in  1  write strobe, active low
- av_writedata  in  32  write data
- av_readdata  out  32  registered read data
- av_waitrequest  out  1  Avalon wait
- av_irq  out  1  registered interrupt
- tx_data  out  DW  TX FIFO head
- tx_valid  out  1  TX FIFO not empty
- tx_ready  in  1  sink accepts a beat
- rx_data  in  DW  incoming beat
- rx_valid  in  1  incoming beat valid
- rx_ready  out  1  block accepts a beat

Behaviour:
- Reset: one clock domain (clk); reset is asynchronous and active-low (rst_n).
  - Outputs: av_waitrequest=1, av_readdata=0, av_irq=0, tx_valid=0.
  - rx_ready = 1 (RX FIFO is empty after reset).
  - Both FIFOs are emptied; WOVF, ROVF and all ien bits are cleared; thresholds take their *_RST values.
- Avalon access timing:
  - av_waitrequest <= ~(av_chipselect & (~av_read_n | ~av_write_n) & av_waitrequest).
  - Every access therefore completes on its 2nd cycle.
  - Side effects (push, pop, register write) happen only on the first-cycle edge, i.e. when waitrequest is 1. Each access acts exactly once.
  - av_readdata is captured at the same edge and is valid while waitrequest is 0.
- Counters: tx_used and rx_used are clog2(DEPTH)+1 bits wide and are zero-extended into 16-bit fields.
- DATA (addr 0):
  - Write: if the TX FIFO is not full, push av_writedata[DW-1:0]; otherwise drop the byte and set WOVF (sticky).
  - Read: if the RX FIFO is not empty, pop it. readdata = {rx_used before the pop [31:16], RVALID [15], zeros, data [DW-1:0]}.
  - A read from an empty RX FIFO returns RVALID=0 and data=0; the FIFO is unchanged.
- CONTROL (addr 1):
  - Write: bit0 ien_rx, bit1 ien_tx, bit2 ien_ovf.
  - Read: [2:0] ien bits, [8] rx_ip, [9] tx_ip, [10] ovf_ip, [31:16] TX free space (TX_DEPTH - tx_used).
- THRESH (addr 2):
  - Read/write: [15:0] tx_thr, [31:16] rx_thr.
  - An rx_thr of 0 behaves as 1.
- STATUS (addr 3):
  - Read: bit0 WOVF, bit1 ROVF, bit2 tx_empty, bit3 rx_full, [31:16] rx_used.
  - Write: writing 1 to bit0 or bit1 clears that flag (write-1-to-clear). If a set event occurs in the same cycle, set wins.
- TX stream:
  - First-word-fall-through FIFO: tx_valid = ~tx_empty, tx_data = head.
  - The head is popped on tx_valid & tx_ready.
- RX stream:
  - A beat is pushed on rx_valid & rx_ready & ~rx_full.
  - With RX_DROP=1, rx_valid while full drops the beat and sets ROVF.
- Full/empty and simultaneous events:
  - Fullness and emptiness are evaluated from the state at the start of the cycle.
  - A push into a full FIFO is rejected even if a pop occurs in the same cycle.
  - A simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo DEPTH.
- Interrupts:
  - rx_ip = ien_rx & (rx_used >= max(rx_thr,1)).
  - tx_ip = ien_tx & (tx_used <= tx_thr).
  - ovf_ip = ien_ovf & (WOVF | ROVF).
  - av_irq <= rx_ip | tx_ip | ovf_ip, registered, so it follows its condition by 1 cycle.
- Reset mid-operation: the current access is abandoned, waitrequest returns to 1, and the FIFO contents are lost.

Test Plan:
- Reset with rst_n low for 3 cycles, then release.
  - Required: waitrequest=1, tx_valid=0, rx_ready=1, av_irq=0.
  - A CONTROL read returns 0x00400000 (64 free); a THRESH read returns 0x00010008.
- Write 0x41, 0x42, 0x43 to DATA with tx_ready=0, then raise tx_ready.
  - Each write completes in 2 cycles.
  - tx_data emits 0x41, 0x42, 0x43 on consecutive cycles, then tx_valid drops.
- With tx_ready=0, write 65 bytes.
  - Required: the 65th byte is dropped, STATUS bit0=1, CONTROL[31:16]=0.
  - Writing STATUS 0x1 clears WOVF.
- Set ien_rx=1 and rx_thr=4, then stream 4 RX beats.
  - Required: av_irq rises 1 cycle after the 4th push.
  - Reading DATA 4 times returns rx_used 4,3,2,1 with RVALID=1.
  - A 5th read returns RVALID=0; av_irq falls after the 1st pop.
- RX_DROP=1, RX_DEPTH=4: send 6 beats with no reads.
  - Required: rx_ready stays 1, STATUS shows ROVF=1 and rx_used=4, and only the first 4 beats are readable.
- With the TX FIFO full, hold tx_ready=1 and issue an Avalon DATA write in the same cycle.
  - Required: the pop occurs, the write is dropped, WOVF=1 and tx_used=63.
- Assert rst_n mid-access while waitrequest=0.
  - Required: all outputs return to their reset values asynchronously.
